uart_tx_arb: RTL and testbench

- Round-robin arbiter that shares one CoreUARTapb transmitter among NUM_REQ byte sources, e.g. firmware, telemetry and debug streams.
- It drives the transmitter's holding-register write interface (tx_data/tx_wr) and paces writes using the transmitter's txrdy status.
- It sits between the requesting blocks and the UART TX path on the system clock. It runs in the non-FIFO transmitter configuration.

---
 rtl/uart_tx_arb_if.sv | 28 ++
 rtl/uart_tx_arb.sv | 222 ++++++++++++++++++++++
 tb/tb_uart_tx_arb.sv | 246 ++++++++++++++++++++++++
 3 files changed

// File: rtl/uart_tx_arb_if.sv
`default_nettype none
//------------------------------------------------------------------------------
// Module   : uart_tx_arb_if
// Brief    : Requester and UART holding-register handshake bundle for uart_tx_arb.
// Revision : 1.0 - initial release
//------------------------------------------------------------------------------
interface uart_tx_arb_if #(
  parameter int NUM_REQ = 4
);
  logic [NUM_REQ-1:0]   req_valid;
  logic [8*NUM_REQ-1:0] req_data;
  logic [NUM_REQ-1:0]   req_ack;
  logic                 txrdy;
  logic [7:0]           tx_data;
  logic                 tx_wr;

  // master: requesters plus transmitter; slave: the arbiter
  modport master (
    output req_valid, req_data, txrdy,
    input  req_ack, tx_data, tx_wr
  );

  modport slave (
    input  req_valid, req_data, txrdy,
    output req_ack, tx_data, tx_wr
  );
endinterface
`default_nettype wire

// File: rtl/uart_tx_arb.sv
`default_nettype none
//------------------------------------------------------------------------------
// Module   : uart_tx_arb
// Brief    : Round-robin arbiter feeding one non-FIFO UART transmitter, paced by
//            txrdy. Optional channel tag prefix when UART_TX_ARB_TAG_EN is defined.
// Revision : 1.0 - initial release
//------------------------------------------------------------------------------
module uart_tx_arb #(
  parameter int NUM_REQ = 4,
  parameter int TMO_CYC = 15
) (
  input  wire logic       clk,
  input  wire logic       reset_n,
  uart_tx_arb_if.slave    bus,
  input  wire logic       err_clr,
  output logic      [3:0] gnt_idx,
  output logic            busy,
  output logic            tx_err
);

  localparam int c_cnt_w = $clog2(TMO_CYC + 1);
  localparam logic [c_cnt_w-1:0] c_tmo_last = c_cnt_w'(TMO_CYC - 1);

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_WR      = 3'd1,
    S_HOLD    = 3'd2,
    S_WAITRDY = 3'd3
`ifdef UART_TX_ARB_TAG_EN
    ,
    S_TAG_WR   = 3'd4,
    S_TAG_HOLD = 3'd5
`endif
  } state_t;

  state_t               r_state,   w_state_nxt;
  logic [c_cnt_w-1:0]   r_cnt,     w_cnt_nxt;
  logic [3:0]           r_rr_ptr,  w_rr_nxt;
  logic [3:0]           r_gnt,     w_gnt_nxt;
  logic [7:0]           r_tx_data, w_tx_data_nxt;
  logic                 r_tx_wr,   w_tx_wr_nxt;
  logic [NUM_REQ-1:0]   r_ack,     w_ack_nxt;
  logic                 r_busy;
  logic                 r_err;
  logic                 w_err_set;
`ifdef UART_TX_ARB_TAG_EN
  logic [7:0]           r_byte,      w_byte_nxt;
  logic                 r_tag_phase, w_tag_nxt;
  logic [NUM_REQ-1:0]   w_gnt_onehot;
`endif

  logic                 w_any;
  logic                 w_hi_found;
  logic [3:0]           w_hi_idx;
  logic [3:0]           w_lo_idx;
  logic [3:0]           w_winner;
  logic [7:0]           w_win_byte;
  logic [NUM_REQ-1:0]   w_win_onehot;

  // Descending scan leaves the lowest matching index in each result
  always_comb begin
    w_any      = 1'b0;
    w_hi_found = 1'b0;
    w_hi_idx   = '0;
    w_lo_idx   = '0;
    for (int k = NUM_REQ - 1; k >= 0; k--) begin
      if (bus.req_valid[k]) begin
        w_any    = 1'b1;
        w_lo_idx = 4'(k);
        if (4'(k) >= r_rr_ptr) begin
          w_hi_found = 1'b1;
          w_hi_idx   = 4'(k);
        end
      end
    end
    w_winner = w_hi_found ? w_hi_idx : w_lo_idx;
  end

  always_comb begin
    w_win_byte   = '0;
    w_win_onehot = '0;
    for (int k = 0; k < NUM_REQ; k++) begin
      if (4'(k) == w_winner) begin
        w_win_byte      = bus.req_data[8*k +: 8];
        w_win_onehot[k] = 1'b1;
      end
    end
  end

`ifdef UART_TX_ARB_TAG_EN
  always_comb begin
    w_gnt_onehot = '0;
    for (int k = 0; k < NUM_REQ; k++) begin
      w_gnt_onehot[k] = (4'(k) == r_gnt);
    end
  end
`endif

  always_comb begin
    w_state_nxt   = r_state;
    w_cnt_nxt     = r_cnt;
    w_rr_nxt      = r_rr_ptr;
    w_gnt_nxt     = r_gnt;
    w_tx_data_nxt = r_tx_data;
    w_tx_wr_nxt   = 1'b0;
    w_ack_nxt     = '0;
    w_err_set     = 1'b0;
`ifdef UART_TX_ARB_TAG_EN
    w_byte_nxt    = r_byte;
    w_tag_nxt     = r_tag_phase;
`endif
    case (r_state)
      S_IDLE: begin
        if (bus.txrdy && w_any) begin
          w_gnt_nxt   = w_winner;
          w_rr_nxt    = (w_winner == 4'(NUM_REQ - 1)) ? 4'd0 : w_winner + 4'd1;
          w_tx_wr_nxt = 1'b1;
`ifdef UART_TX_ARB_TAG_EN
          w_byte_nxt    = w_win_byte;
          w_tx_data_nxt = {4'hA, w_winner};
          w_tag_nxt     = 1'b1;
          w_state_nxt   = S_TAG_WR;
`else
          w_tx_data_nxt = w_win_byte;
          w_ack_nxt     = w_win_onehot;
          w_state_nxt   = S_WR;
`endif
        end
      end
      S_WR: begin
        w_cnt_nxt   = '0;
        w_state_nxt = S_HOLD;
      end
`ifdef UART_TX_ARB_TAG_EN
      S_TAG_WR: begin
        w_cnt_nxt   = '0;
        w_state_nxt = S_TAG_HOLD;
      end
      S_TAG_HOLD: begin
        w_cnt_nxt = r_cnt + 1'b1;
        if (r_cnt != '0 && !bus.txrdy) begin
          w_state_nxt = S_WAITRDY;
        end else if (r_cnt == c_tmo_last) begin
          w_err_set   = 1'b1;
          w_tag_nxt   = 1'b0;
          w_state_nxt = S_IDLE;
        end
      end
`endif
      // First HOLD cycle (r_cnt==0) ignores txrdy: it still reflects pre-strobe status
      S_HOLD: begin
        w_cnt_nxt = r_cnt + 1'b1;
        if (r_cnt != '0 && !bus.txrdy) begin
          w_state_nxt = S_WAITRDY;
        end else if (r_cnt == c_tmo_last) begin
          w_err_set   = 1'b1;
          w_state_nxt = S_IDLE;
        end
      end
      S_WAITRDY: begin
        if (bus.txrdy) begin
`ifdef UART_TX_ARB_TAG_EN
          if (r_tag_phase) begin
            w_tag_nxt     = 1'b0;
            w_tx_data_nxt = r_byte;
            w_tx_wr_nxt   = 1'b1;
            w_ack_nxt     = w_gnt_onehot;
            w_state_nxt   = S_WR;
          end else
`endif
          w_state_nxt = S_IDLE;
        end
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state     <= S_IDLE;
      r_cnt       <= '0;
      r_rr_ptr    <= '0;
      r_gnt       <= '0;
      r_tx_data   <= '0;
      r_tx_wr     <= 1'b0;
      r_ack       <= '0;
      r_busy      <= 1'b0;
      r_err       <= 1'b0;
`ifdef UART_TX_ARB_TAG_EN
      r_byte      <= '0;
      r_tag_phase <= 1'b0;
`endif
    end else begin
      r_state     <= w_state_nxt;
      r_cnt       <= w_cnt_nxt;
      r_rr_ptr    <= w_rr_nxt;
      r_gnt       <= w_gnt_nxt;
      r_tx_data   <= w_tx_data_nxt;
      r_tx_wr     <= w_tx_wr_nxt;
      r_ack       <= w_ack_nxt;
      r_busy      <= (w_state_nxt != S_IDLE);
      if (w_err_set) begin
        r_err <= 1'b1;
      end else if (err_clr) begin
        r_err <= 1'b0;
      end
`ifdef UART_TX_ARB_TAG_EN
      r_byte      <= w_byte_nxt;
      r_tag_phase <= w_tag_nxt;
`endif
    end
  end

  assign bus.tx_data = r_tx_data;
  assign bus.tx_wr   = r_tx_wr;
  assign bus.req_ack = r_ack;
  assign gnt_idx     = r_gnt;
  assign busy        = r_busy;
  assign tx_err      = r_err;

endmodule
`default_nettype wire

// File: tb/tb_uart_tx_arb.sv
`default_nettype none
//------------------------------------------------------------------------------
// Module   : tb_uart_tx_arb
// Brief    : Directed self-checking bench for uart_tx_arb with a simple txrdy model.
// Revision : 1.0 - initial release
//------------------------------------------------------------------------------
module tb_uart_tx_arb;

  localparam int NUM_REQ = 4;

  logic       clk = 1'b0;
  logic       reset_n = 1'b0;
  logic       err_clr = 1'b0;
  logic [3:0] gnt_idx;
  logic       busy;
  logic       tx_err;

  logic       model_en = 1'b1;
  logic       force_rdy = 1'b1;
  logic       model_rdy;
  int         low_cnt;

  int         n_vec = 0;
  int         n_err = 0;

  uart_tx_arb_if #(.NUM_REQ(NUM_REQ)) bus ();

  uart_tx_arb #(.NUM_REQ(NUM_REQ), .TMO_CYC(15)) dut (
    .clk     (clk),
    .reset_n (reset_n),
    .bus     (bus),
    .err_clr (err_clr),
    .gnt_idx (gnt_idx),
    .busy    (busy),
    .tx_err  (tx_err)
  );

  always #5 clk = ~clk;

  // Transmitter: txrdy drops on a strobe and returns 10 cycles later
  always @(negedge clk or negedge reset_n) begin
    if (!reset_n) begin
      model_rdy <= 1'b1;
      low_cnt   <= 0;
    end else if (bus.tx_wr) begin
      model_rdy <= 1'b0;
      low_cnt   <= 10;
    end else if (low_cnt > 0) begin
      low_cnt <= low_cnt - 1;
      if (low_cnt == 1) model_rdy <= 1'b1;
    end
  end

  assign bus.txrdy = model_en ? model_rdy : force_rdy;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(negedge clk);
    #1;
  endtask

  task automatic wait_wr(input string tag);
    bit ok;
    ok = 1'b0;
    for (int i = 0; i < 100; i++) begin
      tick();
      if (bus.tx_wr) begin
        ok = 1'b1;
        break;
      end
    end
    check({tag, "_seen"}, 32'(ok), 32'd1);
  endtask

  task automatic wait_idle(input string tag);
    bit ok;
    ok = 1'b0;
    for (int i = 0; i < 100; i++) begin
      tick();
      if (!busy && bus.txrdy) begin
        ok = 1'b1;
        break;
      end
    end
    check({tag, "_idle"}, 32'(ok), 32'd1);
  endtask

  logic [7:0] dat [NUM_REQ];
  bit         bad;

  initial begin
    bus.req_valid = '0;
    bus.req_data  = '0;
    repeat (3) tick();
    check("rst_tx_wr",   32'(bus.tx_wr),   32'd0);
    check("rst_tx_data", 32'(bus.tx_data), 32'd0);
    check("rst_ack",     32'(bus.req_ack), 32'd0);
    check("rst_gnt",     32'(gnt_idx),     32'd0);
    check("rst_busy",    32'(busy),        32'd0);
    check("rst_err",     32'(tx_err),      32'd0);
    reset_n = 1'b1;
    tick();

    // Round robin with every requester continuously valid
    for (int i = 0; i < NUM_REQ; i++) dat[i] = {4'(i), 4'h0};
    bus.req_data  = {dat[3], dat[2], dat[1], dat[0]};
    bus.req_valid = 4'b1111;
    for (int n = 0; n < 6; n++) begin
      int e;
      e = n % NUM_REQ;
      wait_wr("rr");
      check("rr_gnt",  32'(gnt_idx),     32'(e));
      check("rr_ack",  32'(bus.req_ack), 32'(1 << e));
      check("rr_data", 32'(bus.tx_data), 32'(dat[e]));
      dat[e] = dat[e] + 8'd1;
      bus.req_data = {dat[3], dat[2], dat[1], dat[0]};
      if (n == 5) bus.req_valid = '0;
    end
    wait_idle("rr");

    // Single request, one-cycle grant latency, no further strobes
    bus.req_data  = 32'h0000_5A00;
    bus.req_valid = 4'b0010;
    tick();
    check("t1_wr",   32'(bus.tx_wr),   32'd1);
    check("t1_data", 32'(bus.tx_data), 32'h5A);
    check("t1_ack",  32'(bus.req_ack), 32'b0010);
    check("t1_gnt",  32'(gnt_idx),     32'd1);
    bus.req_valid = '0;
    bad = 1'b0;
    for (int i = 0; i < 12; i++) begin
      tick();
      if (bus.tx_wr || bus.req_ack != '0) bad = 1'b1;
    end
    check("t1_no_extra_wr", 32'(bad),         32'd0);
    check("t1_data_hold",   32'(bus.tx_data), 32'h5A);
    wait_idle("t1");

    // txrdy low blocks grants; grant follows its rise by one cycle
    model_en  = 1'b0;
    force_rdy = 1'b0;
    bus.req_data  = 32'h0000_00C3;
    bus.req_valid = 4'b0001;
    bad = 1'b0;
    for (int i = 0; i < 20; i++) begin
      tick();
      if (bus.tx_wr || busy) bad = 1'b1;
    end
    check("t3_blocked", 32'(bad), 32'd0);
    model_en = 1'b1;
    tick();
    check("t3_wr",   32'(bus.tx_wr),   32'd1);
    check("t3_ack",  32'(bus.req_ack), 32'b0001);
    check("t3_data", 32'(bus.tx_data), 32'hC3);
    bus.req_valid = '0;
    wait_idle("t3");

    // txrdy stuck high: timeout after 15 HOLD cycles, then clear
    model_en  = 1'b0;
    force_rdy = 1'b1;
    bus.req_data  = 32'h0000_7700;
    bus.req_valid = 4'b0010;
    tick();
    check("t4_wr",  32'(bus.tx_wr),   32'd1);
    check("t4_ack", 32'(bus.req_ack), 32'b0010);
    bus.req_valid = '0;
    bad = 1'b0;
    for (int i = 0; i < 15; i++) begin
      tick();
      if (tx_err || !busy) bad = 1'b1;
    end
    check("t4_hold_no_err", 32'(bad), 32'd0);
    tick();
    check("t4_err_set", 32'(tx_err), 32'd1);
    check("t4_idle",    32'(busy),   32'd0);
    tick();
    check("t4_err_sticky", 32'(tx_err), 32'd1);
    err_clr = 1'b1;
    tick();
    err_clr = 1'b0;
    check("t4_err_clr", 32'(tx_err), 32'd0);
    model_en = 1'b1;
    wait_idle("t4");

    // Asynchronous reset in HOLD, then rr pointer restarts at 0
    bus.req_data  = 32'h009C_0000;
    bus.req_valid = 4'b0100;
    tick();
    check("t5_wr",  32'(bus.tx_wr), 32'd1);
    check("t5_gnt", 32'(gnt_idx),   32'd2);
    bus.req_valid = '0;
    tick();
    tick();
    reset_n = 1'b0;
    #1;
    check("t5_rst_busy", 32'(busy),        32'd0);
    check("t5_rst_data", 32'(bus.tx_data), 32'd0);
    check("t5_rst_gnt",  32'(gnt_idx),     32'd0);
    check("t5_rst_wr",   32'(bus.tx_wr),   32'd0);
    check("t5_rst_ack",  32'(bus.req_ack), 32'd0);
    check("t5_rst_err",  32'(tx_err),      32'd0);
    tick();
    tick();
    reset_n = 1'b1;
    tick();
    bus.req_data  = 32'h4433_2211;
    bus.req_valid = 4'b1111;
    wait_wr("t5_post");
    check("t5_post_gnt",  32'(gnt_idx),     32'd0);
    check("t5_post_ack",  32'(bus.req_ack), 32'b0001);
    check("t5_post_data", 32'(bus.tx_data), 32'h11);
    bus.req_valid = '0;
    wait_idle("t5");

    // Requester 2 sends 0x33 (tag prefix only when the feature is built in)
    bus.req_data  = 32'h0033_0000;
    bus.req_valid = 4'b0100;
    tick();
`ifdef UART_TX_ARB_TAG_EN
    check("t6_tag_wr",   32'(bus.tx_wr),   32'd1);
    check("t6_tag_data", 32'(bus.tx_data), 32'hA2);
    check("t6_tag_ack",  32'(bus.req_ack), 32'd0);
    wait_wr("t6_data");
`else
    check("t6_wr", 32'(bus.tx_wr), 32'd1);
`endif
    check("t6_data", 32'(bus.tx_data), 32'h33);
    check("t6_ack",  32'(bus.req_ack), 32'b0100);
    bus.req_valid = '0;
    tick();
    check("t6_ack_once", 32'(bus.req_ack), 32'd0);
    wait_idle("t6");

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
`default_nettype wire
